// File: rtl/otp_pkg.sv
// ============================================================================
// Module  : otp_pkg
// Purpose : Shared constants and cipher primitives for the two-stage OTP
//           encryptor/decryptor pair (data width, default seed, LFSR taps,
//           bit reversal, LFSR step, encrypt and decrypt stage functions).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package otp_pkg;

   localparam int          C_WIDTH        = 64;
   localparam logic [63:0] C_DEFAULT_SEED = 64'h0000_0000_0000_0001;

   // Feedback taps of the 64-bit keystream LFSR
   localparam int C_TAP_A = 63;
   localparam int C_TAP_B = 62;
   localparam int C_TAP_C = 60;
   localparam int C_TAP_D = 59;

   function automatic logic [63:0] rev64(input logic [63:0] x);
      logic [63:0] r;
      for (int i = 0; i < 64; i++) begin
         r[i] = x[63-i];
      end
      return r;
   endfunction

   function automatic logic [63:0] lfsr_next(input logic [63:0] k);
      return {k[62:0], k[C_TAP_A] ^ k[C_TAP_B] ^ k[C_TAP_C] ^ k[C_TAP_D]};
   endfunction

   // Encrypt stage; exact inverse of dec_stage for the same key
   function automatic logic [63:0] enc_stage(input logic [63:0] x, input logic [63:0] k);
      return rev64(~rev64(x ^ k));
   endfunction

   function automatic logic [63:0] dec_stage(input logic [63:0] c, input logic [63:0] k);
      return rev64(~rev64(c)) ^ k;
   endfunction

endpackage

`default_nettype wire

// File: rtl/otp_keystream.sv
// ============================================================================
// Module  : otp_keystream
// Purpose : 64-bit LFSR keystream. Presents the current state K_n and the next
//           state K_n+1; advances by two steps when i_adv is high.
//           Optional reload port when KEY_RELOAD_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module otp_keystream
   import otp_pkg::*;
#(
   parameter logic [63:0] SEED = C_DEFAULT_SEED
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_adv,
`ifdef KEY_RELOAD_EN
   input  logic        i_load,
   input  logic [63:0] i_seed,
`endif
   output logic [63:0] o_k0,
   output logic [63:0] o_k1
);

   logic [63:0] r_state;
   logic [63:0] w_k1;

   assign w_k1 = lfsr_next(r_state);
   assign o_k0 = r_state;
   assign o_k1 = w_k1;

   // LFSR state: restart at SEED, optional reload, two steps per consumed key pair
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= SEED;
`ifdef KEY_RELOAD_EN
      end else if (i_load) begin
         // A zero seed would lock the LFSR, so fall back to SEED
         r_state <= (i_seed == 64'd0) ? SEED : i_seed;
`endif
      end else if (i_adv) begin
         r_state <= lfsr_next(w_k1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/twostage_encryption_otp.sv
// ============================================================================
// Module  : twostage_encryption_otp
// Purpose : Two-stage registered OTP encryptor with internal LFSR keystream
//           and valid/ready handshake on both sides (full backpressure).
//           chiper = plain ^ K_n ^ K_n+1.
//           Optional macro KEY_RELOAD_EN adds key_load/key_seed reload ports.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module twostage_encryption_otp
   import otp_pkg::*;
#(
   parameter logic [63:0] SEED  = C_DEFAULT_SEED,
   parameter int          WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] plain,
   output logic             out_valid,
   input  logic             out_ready,
`ifdef KEY_RELOAD_EN
   input  logic             key_load,
   input  logic [63:0]      key_seed,
`endif
   output logic [WIDTH-1:0] chiper
);

   generate
      if (WIDTH != C_WIDTH) begin : g_bad_width
         $error("twostage_encryption_otp: WIDTH must be 64");
      end
      if (SEED == 64'd0) begin : g_bad_seed
         $error("twostage_encryption_otp: SEED must be nonzero");
      end
   endgenerate

   logic [63:0] w_ka;
   logic [63:0] w_kb;
   logic        w_accept;
   logic        w_s1_adv;
   logic        w_in_ready;

   logic [63:0] r_s1_data;
   logic [63:0] r_s1_key;
   logic        r_s1_valid;
   logic [63:0] r_s2_data;
   logic        r_s2_valid;

   // s1 moves on whenever s2 is empty or is being drained this cycle
   assign w_s1_adv = r_s1_valid && (!r_s2_valid || out_ready);

`ifdef KEY_RELOAD_EN
   assign w_in_ready = !rst && !key_load && (!r_s1_valid || w_s1_adv);
`else
   assign w_in_ready = !rst && (!r_s1_valid || w_s1_adv);
`endif

   assign w_accept  = in_valid && w_in_ready;
   assign in_ready  = w_in_ready;
   assign out_valid = r_s2_valid;
   assign chiper    = r_s2_data;

   otp_keystream #(
      .SEED (SEED)
   ) u_keystream (
      .clk    (clk),
      .rst    (rst),
      .i_adv  (w_accept),
`ifdef KEY_RELOAD_EN
      .i_load (key_load),
      .i_seed (key_seed),
`endif
      .o_k0   (w_ka),
      .o_k1   (w_kb)
   );

   // Stage 1: encrypt with Kb on accept and carry Ka along for stage 2
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_data  <= '0;
         r_s1_key   <= '0;
         r_s1_valid <= 1'b0;
      end else if (w_accept) begin
         r_s1_data  <= enc_stage(plain, w_kb);
         r_s1_key   <= w_ka;
         r_s1_valid <= 1'b1;
      end else if (w_s1_adv) begin
         r_s1_valid <= 1'b0;
      end
   end

   // Stage 2: encrypt with the carried Ka; data holds while stalled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_data  <= '0;
         r_s2_valid <= 1'b0;
      end else if (w_s1_adv) begin
         r_s2_data  <= enc_stage(r_s1_data, r_s1_key);
         r_s2_valid <= 1'b1;
      end else if (r_s2_valid && out_ready) begin
         r_s2_valid <= 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: doc/twostage_encryption_otp.md
Name: twostage_encryption_otp

Overview:
- Transmit-side counterpart of the two-stage OTP decryptor: takes 64-bit plaintext words and produces the ciphertext that decryptor inverts.
- Two registered cipher stages with an internal 64-bit LFSR keystream.
- Valid/ready handshake on both sides, full backpressure, no word loss.
- Sits between the plaintext source and the channel/storage feeding the decryptor.

Parameters:
- SEED, 64'h0000_0000_0000_0001, LFSR reset value; must be nonzero.
- WIDTH, 64, data width; fixed at 64 and checked at elaboration.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  plaintext word present.
- in_ready  output  1  block accepts word this cycle.
- plain  input  64  plaintext word.
- out_valid  output  1  ciphertext word present.
- out_ready  input  1  sink accepts word this cycle.
- chiper  output  64  ciphertext word.

Behaviour:
- Clock and reset: one clock (clk). Reset rst is asynchronous, active-high.
- Reset values: LFSR=SEED, s1_valid=0, s2_valid=0, out_valid=0, chiper=0, in_ready=1 once rst deasserts.
- Primitives:
  - rev(x): bit reversal.
  - E(x,k) = rev(~rev(x ^ k)), which is the inverse of the decryptor stage D(c,k) = rev(~rev(c)) ^ k.
- LFSR step: next = {K[62:0], K[63]^K[62]^K[60]^K[59]}.
- Key pair per accepted word: Ka = current LFSR state K_n, Kb = K_{n+1}. The LFSR advances two steps on each accept (in_valid && in_ready) and holds otherwise.
- Stage 1 (on accept): s1_data <= E(plain, Kb), s1_key <= Ka, s1_valid <= 1.
- Stage 2 (on s1 advance): s2_data <= E(s1_data, s1_key), s2_valid <= 1.
- Net result: chiper = plain ^ Ka ^ Kb. The matching decryptor uses x1=K_n and x2=K_{n+1}.
- Handshake: out_valid = s2_valid and chiper = s2_data.
  - s2 drains when out_valid && out_ready.
  - s1 advances when s1_valid && (!s2_valid || out_ready).
  - in_ready = !s1_valid || s1_advance (combinational from out_ready; no skid buffer).
- Latency: 2 cycles from accept to out_valid with no backpressure. Throughput: 1 word/cycle.
- Pipeline full (s1 and s2 valid, out_ready=0): in_ready=0, all registers and LFSR hold, chiper stable while out_valid=1.
- Simultaneous accept and drain: allowed in the same cycle; no bubble is inserted.
- in_valid while in_ready=0: no state change, no key consumed.
- LFSR wrap-around: free-running period; never all-zero given a nonzero SEED.
- Reset mid-operation: in-flight words are discarded, out_valid drops asynchronously, keystream restarts at SEED. The peer must also be reset for key alignment.

Optional Feature:
- Macro: KEY_RELOAD_EN.
- With the macro defined:
  - Extra inputs key_load (1 bit) and key_seed (64 bits).
  - key_load=1 forces in_ready=0 that cycle and loads LFSR <= key_seed, or SEED if key_seed==0.
  - Words already in s1/s2 keep their captured keys and complete normally.
- Without the macro: no extra ports; the LFSR is reloaded only by rst.

Decomposition:
- Shared package otp_pkg:
  - WIDTH constant and default SEED.
  - Tap positions (63,62,60,59).
  - Functions rev64, lfsr_next, enc_stage, dec_stage.
  - The decryptor imports the same package.
- One natural sub-module, otp_keystream: LFSR with a step-by-two advance enable and optional reload, outputting K_n and K_{n+1}.

Test Plan:
- Reset, SEED=1, out_ready=1, send plain=0 -> out_valid after 2 cycles, chiper=64'h3.
- Second word plain=64'hFFFF_FFFF_FFFF_FFFF -> chiper=64'hFFFF_FFFF_FFFF_FFF3 (keys 4 and 8).
- Hold out_ready=0, stream 4 words -> exactly 2 accepted, in_ready=0, chiper stable. Release -> all 4 out in order, keys uninterrupted.
- Loopback through the decryptor (shared reset, keys K_n/K_{n+1}), 1000 random words with random valid/ready -> plain recovered bit-exact.
- Assert rst mid-stream -> out_valid=0 immediately. Next word plain=0 -> chiper=64'h3.
- KEY_RELOAD_EN: key_load with key_seed=64'h10, then plain=0 -> chiper=64'h30. key_seed=0 -> behaves as SEED.
